// File: rtl/riscv_retire_monitor_pkg.sv
// Shared definitions for the retire monitor: FSM state codes, the tohost
// pass value, internal counter widths and the signature update step.
package riscv_retire_monitor_pkg;

  typedef enum logic [1:0] {
    MON_RUN   = 2'd0,
    MON_DRAIN = 2'd1,
    MON_DONE  = 2'd2
  } mon_state_e;

  localparam logic [31:0] TOHOST_PASS = 32'h1;

  // Widths of the stuck-PC and drain counters; both only need to reach
  // their small thresholds, saturation keeps them safe past that.
  localparam int STUCK_W = 16;
  localparam int DRAIN_W = 16;

  // One signature step: rotate left by one, fold in data and address.
  function automatic logic [31:0] sig_step(input logic [31:0] sig,
                                           input logic [4:0]  wa,
                                           input logic [31:0] wd);
    return {sig[30:0], sig[31]} ^ wd ^ {27'd0, wa};
  endfunction

endpackage

// File: rtl/riscv_retire_monitor_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   CLK  - clock, rising edge
//   RSTn - asynchronous active-low reset (q -> 0)
//   en   - count enable
//   clr  - synchronous clear, wins over en
//   q    - count value
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/riscv_retire_monitor.sv
// riscv_retire_monitor: end-of-test monitor for the core harness.
// Snoops write-back, D-memory stores and the fetch PC; accumulates a
// register-write signature plus retire/cycle counts, decides PASS / FAIL /
// HUNG, then raises DONE once the pipeline-drain window has elapsed.
// Ports:
//   CLK, RSTn                 - clock (rising) / async active-low reset
//   RF_WE, RF_WA, RF_WD       - register-file write-back port
//   I_MEM_CSN, I_MEM_ADDR     - fetch strobe (active low) and PC
//   D_MEM_CSN, D_MEM_WEN,
//   D_MEM_ADDR, D_MEM_DOUT    - D-memory store port (strobes active low)
//   DONE                      - test finished, sticky until reset
//   PASS / FAIL / HUNG        - verdict, at most one ever set
//   FAIL_CODE                 - tohost data[31:1] on FAIL, else 0
//   SIG                       - write-back signature
//   RETIRE_CNT, CYCLE_CNT     - retired RF writes / cycles in RUN+DRAIN
//   STATE                     - current FSM state (debug visibility)
module riscv_retire_monitor
  import riscv_retire_monitor_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_0FF0,
  parameter int          DRAIN_CYCLES = 8,
  parameter int          STUCK_CYCLES = 16,
  parameter int          TIMEOUT      = 100000
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        RF_WE,
  input  logic [4:0]  RF_WA,
  input  logic [31:0] RF_WD,
  input  logic        I_MEM_CSN,
  input  logic [31:0] I_MEM_ADDR,
  input  logic        D_MEM_CSN,
  input  logic        D_MEM_WEN,
  input  logic [31:0] D_MEM_ADDR,
  input  logic [31:0] D_MEM_DOUT,
  output logic        DONE,
  output logic        PASS,
  output logic        FAIL,
  output logic        HUNG,
  output logic [30:0] FAIL_CODE,
  output logic [31:0] SIG,
  output logic [31:0] RETIRE_CNT,
  output logic [31:0] CYCLE_CNT,
  output mon_state_e  STATE
);

  // The stuck counter counts matching fetches after the first one, so the
  // Nth identical fetch moves it from N-2 to N-1; detect that step.
  localparam logic [STUCK_W-1:0] STUCK_HIT   = STUCK_W'(STUCK_CYCLES - 2);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST  = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [31:0]        TIMEOUT_HIT = 32'(TIMEOUT - 1);

  mon_state_e         state_q, state_d;
  logic               pass_q, fail_q, hung_q;
  logic [30:0]        fail_code_q;
  logic [31:0]        sig_q;
  logic [31:0]        last_pc_q;
  logic               pc_valid_q;
  logic [STUCK_W-1:0] stuck_cnt;
  logic [DRAIN_W-1:0] drain_cnt;

  logic active, in_run, in_drain, fetch, pc_match, retire;
  logic tohost_ev, stuck_ev, timeout_ev;
  logic set_pass, set_fail, set_hung;

  assign active   = (state_q != MON_DONE);
  assign in_run   = (state_q == MON_RUN);
  assign in_drain = (state_q == MON_DRAIN);
  assign fetch    = active && !I_MEM_CSN;
  assign pc_match = fetch && pc_valid_q && (I_MEM_ADDR == last_pc_q);
  assign retire   = active && RF_WE && (RF_WA != 5'd0);

  assign tohost_ev  = !D_MEM_CSN && !D_MEM_WEN && (D_MEM_ADDR == TOHOST_ADDR)
                      && (D_MEM_DOUT != 32'd0);
  assign stuck_ev   = pc_match && (stuck_cnt == STUCK_HIT);
  assign timeout_ev = (CYCLE_CNT == TIMEOUT_HIT);

  // Next-state and verdict selection. End events only matter in RUN, where
  // a tohost store outranks a self-loop, which outranks the timeout.
  always_comb begin
    state_d  = state_q;
    set_pass = 1'b0;
    set_fail = 1'b0;
    set_hung = 1'b0;
    case (state_q)
      MON_RUN: begin
        if (tohost_ev) begin
          state_d = MON_DRAIN;
          if (D_MEM_DOUT == TOHOST_PASS) set_pass = 1'b1;
          else                           set_fail = 1'b1;
        end else if (stuck_ev || timeout_ev) begin
          state_d  = MON_DRAIN;
          set_hung = 1'b1;
        end
      end
      MON_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_d = MON_DONE;
      end
      default: state_d = MON_DONE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= MON_RUN;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      hung_q      <= 1'b0;
      fail_code_q <= '0;
      sig_q       <= '0;
      last_pc_q   <= '0;
      pc_valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_pass) pass_q <= 1'b1;
      if (set_fail) begin
        fail_q      <= 1'b1;
        fail_code_q <= D_MEM_DOUT[31:1];
      end
      if (set_hung) hung_q <= 1'b1;
      if (retire) sig_q <= sig_step(sig_q, RF_WA, RF_WD);
      // A fetch of a new PC restarts loop tracking from that PC.
      if (fetch && !pc_match) begin
        last_pc_q  <= I_MEM_ADDR;
        pc_valid_q <= 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(32)) u_retire_cnt (
    .CLK(CLK), .RSTn(RSTn), .en(retire), .clr(1'b0), .q(RETIRE_CNT)
  );

  sat_counter #(.WIDTH(32)) u_cycle_cnt (
    .CLK(CLK), .RSTn(RSTn), .en(active), .clr(1'b0), .q(CYCLE_CNT)
  );

  // Stall cycles (I_MEM_CSN high) neither advance nor clear the count.
  sat_counter #(.WIDTH(STUCK_W)) u_stuck_cnt (
    .CLK(CLK), .RSTn(RSTn), .en(pc_match), .clr(fetch && !pc_match),
    .q(stuck_cnt)
  );

  sat_counter #(.WIDTH(DRAIN_W)) u_drain_cnt (
    .CLK(CLK), .RSTn(RSTn), .en(in_drain), .clr(in_run), .q(drain_cnt)
  );

  assign DONE      = (state_q == MON_DONE);
  assign PASS      = pass_q;
  assign FAIL      = fail_q;
  assign HUNG      = hung_q;
  assign FAIL_CODE = fail_code_q;
  assign SIG       = sig_q;
  assign STATE     = state_q;

endmodule
